// File: rtl/mem_arb_if.sv
// Requester, memory-port and status signals of the shared-memory arbiter.
// The arbiter connects through the slave modport; requesters and memory through master.
interface mem_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_done;
  logic [DATA_W-1:0] fetch_rdata;
  logic              fetch_err;
  logic              fetch_stall;

  logic              ldst_req;
  logic              ldst_wr;
  logic [ADDR_W-1:0] ldst_addr;
  logic [DATA_W-1:0] ldst_wdata;
  logic              ldst_done;
  logic [DATA_W-1:0] ldst_rdata;
  logic              ldst_err;
  logic              ldst_stall;

  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_err;

  logic              busy;

  modport slave (
    input  fetch_req, fetch_addr,
    input  ldst_req, ldst_wr, ldst_addr, ldst_wdata,
    input  mem_data_out, mem_err,
    output fetch_done, fetch_rdata, fetch_err, fetch_stall,
    output ldst_done, ldst_rdata, ldst_err, ldst_stall,
    output mem_enable, mem_wr, mem_addr, mem_data_in,
    output busy
  );

  modport master (
    output fetch_req, fetch_addr,
    output ldst_req, ldst_wr, ldst_addr, ldst_wdata,
    output mem_data_out, mem_err,
    input  fetch_done, fetch_rdata, fetch_err, fetch_stall,
    input  ldst_done, ldst_rdata, ldst_err, ldst_stall,
    input  mem_enable, mem_wr, mem_addr, mem_data_in,
    input  busy
  );
endinterface

// File: rtl/mem_arb.sv
// Arbiter/sequencer for the shared memory: one access at a time, memory stage first,
// fetch forced after STARVE_MAX consecutive memory-stage grants while it waits.
module mem_arb #(
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic clk,
  input  logic rst,
  mem_arb_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]    LAT_LIM    = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              owner_ldst_q, owner_ldst_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic              fetch_err_q, fetch_err_d;
  logic [DATA_W-1:0] ldst_rdata_q, ldst_rdata_d;
  logic              ldst_err_q, ldst_err_d;
  logic              force_fetch;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_ldst_q  <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      lat_cnt_q     <= '0;
      starve_cnt_q  <= '0;
      fetch_rdata_q <= '0;
      fetch_err_q   <= 1'b0;
      ldst_rdata_q  <= '0;
      ldst_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_ldst_q  <= owner_ldst_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      lat_cnt_q     <= lat_cnt_d;
      starve_cnt_q  <= starve_cnt_d;
      fetch_rdata_q <= fetch_rdata_d;
      fetch_err_q   <= fetch_err_d;
      ldst_rdata_q  <= ldst_rdata_d;
      ldst_err_q    <= ldst_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_ldst_d    = owner_ldst_q;
    wr_d            = wr_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    lat_cnt_d       = lat_cnt_q;
    starve_cnt_d    = starve_cnt_q;
    fetch_rdata_d   = fetch_rdata_q;
    fetch_err_d     = fetch_err_q;
    ldst_rdata_d    = ldst_rdata_q;
    ldst_err_d      = ldst_err_q;
    force_fetch     = 1'b0;
    bus.mem_enable  = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;

    case (state_q)
      IDLE: begin
        if (bus.ldst_req || bus.fetch_req) begin
          force_fetch = bus.fetch_req && (starve_cnt_q == STARVE_LIM);
          if (bus.ldst_req && !force_fetch) begin
            owner_ldst_d = 1'b1;
            wr_d         = bus.ldst_wr;
            addr_d       = bus.ldst_addr;
            wdata_d      = bus.ldst_wdata;
            if (!bus.fetch_req)
              starve_cnt_d = '0;
            else if (starve_cnt_q != STARVE_LIM)
              starve_cnt_d = starve_cnt_q + SW'(1);
          end else begin
            owner_ldst_d = 1'b0;
            wr_d         = 1'b0;
            addr_d       = bus.fetch_addr;
            wdata_d      = '0;
            starve_cnt_d = '0;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        bus.mem_enable  = 1'b1;
        bus.mem_wr      = wr_q;
        bus.mem_addr    = addr_q;
        bus.mem_data_in = wdata_q;
        lat_cnt_d       = 4'd1;
        state_d         = WAIT;
      end

      WAIT: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        // Memory response is valid in this cycle; a store leaves the load data untouched.
        if (lat_cnt_q == LAT_LIM) begin
          if (owner_ldst_q) begin
            ldst_err_d = bus.mem_err;
            if (!wr_q)
              ldst_rdata_d = bus.mem_data_out;
          end else begin
            fetch_err_d   = bus.mem_err;
            fetch_rdata_d = bus.mem_data_out;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fetch_done  = (state_q == RESP) && !owner_ldst_q;
  assign bus.ldst_done   = (state_q == RESP) && owner_ldst_q;
  assign bus.fetch_rdata = fetch_rdata_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.ldst_rdata  = ldst_rdata_q;
  assign bus.ldst_err    = ldst_err_q;
  assign bus.fetch_stall = bus.fetch_req && !bus.fetch_done;
  assign bus.ldst_stall  = bus.ldst_req && !bus.ldst_done;
  assign bus.busy        = (state_q != IDLE);

endmodule
